// File: rtl/branch_scan_pkg.sv
// Shared definitions for the loop-branch bracket scanner: instruction opcodes
// and scan FSM states.
package branch_scan_pkg;

  localparam int unsigned InstrW = 9;
  localparam int unsigned DepthW = 8;

  // Opcode lives in the top four instruction bits; the low five are an immediate.
  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpInc   = 4'd1,
    OpDec   = 4'd2,
    OpRight = 4'd3,
    OpLeft  = 4'd4,
    OpOut   = 4'd5,
    OpIn    = 4'd6,
    OpBf    = 4'd7,
    OpBb    = 4'd8
  } op_code;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_t;

  function automatic op_code decode_op(input logic [InstrW-1:0] instr);
    return op_code'(instr[InstrW-1:InstrW-4]);
  endfunction

  function automatic logic [InstrW-1:0] encode_op(input op_code op);
    return {op, 5'd0};
  endfunction

endpackage

// File: rtl/branch_scan.sv
// Walks instruction memory from a taken loop bracket to its matching partner,
// reporting target PC and jump distance while stalling fetch.
module branch_scan
  import branch_scan_pkg::*;
#(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned DIST_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                dir_i,
  input  logic [PC_W-1:0]     start_pc_i,
  output logic [PC_W-1:0]     imem_addr_o,
  input  logic [InstrW-1:0]   imem_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [PC_W-1:0]     target_pc_o,
  output logic [DIST_W-1:0]   distance_o
);

  localparam logic [PC_W-1:0]   PcOne    = 1;
  localparam logic [PC_W-1:0]   LastAddr = '1;
  localparam logic [DIST_W-1:0] DistOne  = 1;
  localparam logic [DIST_W-1:0] DistMax  = '1;
  localparam logic [DepthW-1:0] DepthOne = 1;
  localparam logic [DepthW-1:0] DepthMax = '1;

  scan_state_t       state_q, state_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [DIST_W-1:0] distance_q, distance_d;

  op_code op;
  logic   is_open, is_close, at_edge, start_at_edge;

  always_comb begin
    op       = decode_op(imem_data_i);
    // Backward scans seek the open bracket, so bracket roles swap.
    is_open  = dir_q ? (op == OpBb) : (op == OpBf);
    is_close = dir_q ? (op == OpBf) : (op == OpBb);
    at_edge  = dir_q ? (addr_q == '0) : (addr_q == LastAddr);
    start_at_edge = dir_i ? (start_pc_i == '0) : (start_pc_i == LastAddr);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dist_d     = dist_q;
    depth_d    = depth_q;
    dir_d      = dir_q;
    err_d      = err_q;
    target_d   = target_q;
    distance_d = distance_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          dir_d      = dir_i;
          depth_d    = DepthOne;
          dist_d     = DistOne;
          err_d      = 1'b0;
          target_d   = '0;
          distance_d = '0;
          if (start_at_edge) begin
            err_d    = 1'b1;
            target_d = start_pc_i;
            state_d  = StDone;
          end else begin
            addr_d  = dir_i ? (start_pc_i - PcOne) : (start_pc_i + PcOne);
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (is_close && depth_q == DepthOne) begin
          // A match on the boundary address still counts as a match.
          err_d      = 1'b0;
          target_d   = addr_q;
          distance_d = dist_q;
          state_d    = StDone;
        end else if (at_edge || dist_q == DistMax || (is_open && depth_q == DepthMax)) begin
          err_d      = 1'b1;
          target_d   = addr_q;
          distance_d = dist_q;
          state_d    = StDone;
        end else begin
          if (is_open) begin
            depth_d = depth_q + DepthOne;
          end else if (is_close) begin
            depth_d = depth_q - DepthOne;
          end
          addr_d = dir_q ? (addr_q - PcOne) : (addr_q + PcOne);
          dist_d = dist_q + DistOne;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      dist_q     <= '0;
      depth_q    <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      target_q   <= '0;
      distance_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dist_q     <= dist_d;
      depth_q    <= depth_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      target_q   <= target_d;
      distance_q <= distance_d;
    end
  end

  assign imem_addr_o = (state_q == StIdle) ? start_pc_i : addr_q;
  assign busy_o      = (state_q == StScan);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;
  assign target_pc_o = target_q;
  assign distance_o  = distance_q;

endmodule
